// File: rtl/pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_pkg
// Description : Shared defaults and per-slice control record for the pipe_reg
//               ready/valid pipeline register.
// Contents    : c_DEFAULT_WIDTH, c_DEFAULT_DEPTH, stage_ctrl_t
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_reg_pkg;

  localparam int unsigned c_DEFAULT_WIDTH = 8;
  localparam int unsigned c_DEFAULT_DEPTH = 2;

  // Control presented to one slice each cycle.
  typedef struct packed {
    logic load;   // slice may take its upstream valid/data at the next edge
    logic clear;  // drop the valid flag at the next edge (data kept)
  } stage_ctrl_t;

endpackage : pipe_reg_pkg
`default_nettype wire

// File: rtl/pipe_reg_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage
// Description : One slice of the pipeline register: an enabled, resettable
//               data register plus its valid flag.
// Ports       : clk_i, reset_i (async, active high)
//               i_load     - accept upstream valid (and data if valid)
//               i_up_valid - upstream valid
//               i_up_data  - upstream payload
//               i_clear    - synchronous clear of the valid flag
//               o_valid    - slice valid flag
//               o_data     - slice payload
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage #(
  parameter int                 WidthP      = 8,
  parameter logic [WidthP-1:0]  ResetValueP = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              i_load,
  input  logic              i_up_valid,
  input  logic [WidthP-1:0] i_up_data,
  input  logic              i_clear,
  output logic              o_valid,
  output logic [WidthP-1:0] o_data
);

  logic              r_valid;
  logic [WidthP-1:0] r_data;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_up_valid;
    end
  end

  // Data only moves when a real word arrives; bubbles leave it untouched,
  // and a clear keeps the last payload visible on the output.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_data <= ResetValueP;
    end else if (!i_clear && i_load && i_up_valid) begin
      r_data <= i_up_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule : pipe_stage
`default_nettype wire

// File: rtl/pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg
// Description : Parametrised ready/valid pipeline register built from DepthP
//               full-throughput slices. Supports synchronous flush and
//               reports its occupancy.
// Ports       : clk_i, reset_i (async, active high), flush_i
//               valid_i / ready_o / data_i  - producer side
//               valid_o / ready_i / data_o  - consumer side
//               count_o                     - number of valid slices
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int                WidthP      = c_DEFAULT_WIDTH,
  parameter int                DepthP      = c_DEFAULT_DEPTH,
  parameter logic [WidthP-1:0] ResetValueP = '0
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        flush_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [WidthP-1:0]           data_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [WidthP-1:0]           data_o,
  output logic [$clog2(DepthP+1)-1:0] count_o
);

  localparam int CountWidthL = $clog2(DepthP+1);

  // Parameter sanity checks at elaboration.
  if (WidthP < 1) begin : g_bad_width
    $error("pipe_reg: WidthP must be >= 1");
  end
  if (DepthP < 1) begin : g_bad_depth
    $error("pipe_reg: DepthP must be >= 1");
  end

  logic [DepthP-1:0] w_valid;
  logic [WidthP-1:0] w_data [DepthP];
  logic [DepthP-1:0] w_rdy;
  stage_ctrl_t       w_ctrl [DepthP];
  logic [CountWidthL-1:0] w_count;

  // Ready ripples from the output slice back to the input slice. An empty
  // slice always accepts, which is what squeezes bubbles out under
  // backpressure.
  always_comb begin
    w_rdy = '0;
    w_rdy[DepthP-1] = !w_valid[DepthP-1] || ready_i;
    for (int k = DepthP-2; k >= 0; k--) begin
      w_rdy[k] = !w_valid[k] || w_rdy[k+1];
    end
  end

  always_comb begin
    w_count = '0;
    for (int k = 0; k < DepthP; k++) begin
      w_count = w_count + CountWidthL'(w_valid[k]);
    end
  end

  for (genvar k = 0; k < DepthP; k++) begin : g_stage
    logic              w_up_valid;
    logic [WidthP-1:0] w_up_data;
    logic [WidthP-1:0] w_stage_data;

    if (k == 0) begin : g_head_in
      assign w_up_valid = valid_i;
      assign w_up_data  = data_i;
    end else begin : g_chain_in
      assign w_up_valid = w_valid[k-1];
      assign w_up_data  = w_data[k-1];
    end

    assign w_ctrl[k].load  = w_rdy[k] && !flush_i;
    assign w_ctrl[k].clear = flush_i;

    pipe_stage #(
      .WidthP      (WidthP),
      .ResetValueP (ResetValueP)
    ) u_stage (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .i_load     (w_ctrl[k].load),
      .i_up_valid (w_up_valid),
      .i_up_data  (w_up_data),
      .i_clear    (w_ctrl[k].clear),
      .o_valid    (w_valid[k]),
      .o_data     (w_stage_data)
    );

    assign w_data[k] = w_stage_data;
  end

  // Flush blocks both handshakes in the cycle it is asserted.
  assign ready_o = w_rdy[0] && !flush_i;
  assign valid_o = w_valid[DepthP-1] && !flush_i;
  assign data_o  = w_data[DepthP-1];
  assign count_o = w_count;

endmodule : pipe_reg
`default_nettype wire

// File: tb/tb_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_reg
// Description : Self-checking bench for pipe_reg: directed vector table on a
//               DepthP=3 instance, hand sequences for async reset, and a
//               scoreboard stress on a DepthP=1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_reg;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // DepthP = 3 instance
  logic       a_flush = 1'b0, a_valid = 1'b0, a_ready = 1'b0;
  logic [7:0] a_din = '0;
  logic       a_ready_o, a_valid_o;
  logic [7:0] a_dout;
  logic [1:0] a_count;

  pipe_reg #(.WidthP(8), .DepthP(3), .ResetValueP(8'hA5)) u_d3 (
    .clk_i(clk), .reset_i(reset), .flush_i(a_flush),
    .valid_i(a_valid), .ready_o(a_ready_o), .data_i(a_din),
    .valid_o(a_valid_o), .ready_i(a_ready), .data_o(a_dout),
    .count_o(a_count)
  );

  // DepthP = 1 instance
  logic       b_flush = 1'b0, b_valid = 1'b0, b_ready = 1'b0;
  logic [7:0] b_din = '0;
  logic       b_ready_o, b_valid_o;
  logic [7:0] b_dout;
  logic [0:0] b_count;

  pipe_reg #(.WidthP(8), .DepthP(1), .ResetValueP(8'h00)) u_d1 (
    .clk_i(clk), .reset_i(reset), .flush_i(b_flush),
    .valid_i(b_valid), .ready_o(b_ready_o), .data_i(b_din),
    .valid_o(b_valid_o), .ready_i(b_ready), .data_o(b_dout),
    .count_o(b_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       flush;
    logic       exp_rdy;
    logic       exp_vld;
    logic [7:0] exp_data;
    logic [1:0] exp_cnt;
  } vec_t;

  vec_t vecs [29];

  function automatic vec_t mk(logic v, logic [7:0] d, logic r, logic f,
                              logic er, logic ev, logic [7:0] ed,
                              logic [1:0] ec);
    vec_t t;
    t.valid = v; t.data = d; t.ready = r; t.flush = f;
    t.exp_rdy = er; t.exp_vld = ev; t.exp_data = ed; t.exp_cnt = ec;
    return t;
  endfunction

  logic [7:0] q [$];
  int n_out;

  initial begin
    // Fill / drain with ready_i held high
    vecs[0]  = mk(1, 8'h11, 1, 0, 1, 0, 8'hA5, 0);
    vecs[1]  = mk(1, 8'h22, 1, 0, 1, 0, 8'hA5, 1);
    vecs[2]  = mk(1, 8'h33, 1, 0, 1, 0, 8'hA5, 2);
    vecs[3]  = mk(0, 8'h00, 1, 0, 1, 1, 8'h11, 3);
    vecs[4]  = mk(0, 8'h00, 1, 0, 1, 1, 8'h22, 2);
    vecs[5]  = mk(0, 8'h00, 1, 0, 1, 1, 8'h33, 1);
    vecs[6]  = mk(0, 8'h00, 1, 0, 1, 0, 8'h33, 0);
    // Backpressure: four words offered, three fit
    vecs[7]  = mk(1, 8'h44, 0, 0, 1, 0, 8'h33, 0);
    vecs[8]  = mk(1, 8'h55, 0, 0, 1, 0, 8'h33, 1);
    vecs[9]  = mk(1, 8'h66, 0, 0, 1, 0, 8'h33, 2);
    vecs[10] = mk(1, 8'h77, 0, 0, 0, 1, 8'h44, 3);
    vecs[11] = mk(1, 8'h77, 1, 0, 1, 1, 8'h44, 3);
    vecs[12] = mk(0, 8'h00, 0, 0, 0, 1, 8'h55, 3);
    vecs[13] = mk(0, 8'h00, 1, 0, 1, 1, 8'h55, 3);
    vecs[14] = mk(0, 8'h00, 1, 0, 1, 1, 8'h66, 2);
    vecs[15] = mk(0, 8'h00, 1, 0, 1, 1, 8'h77, 1);
    vecs[16] = mk(0, 8'h00, 0, 0, 1, 0, 8'h77, 0);
    // Bubble collapse: A, gap, B under backpressure
    vecs[17] = mk(1, 8'hA1, 0, 0, 1, 0, 8'h77, 0);
    vecs[18] = mk(0, 8'h00, 0, 0, 1, 0, 8'h77, 1);
    vecs[19] = mk(1, 8'hB2, 0, 0, 1, 0, 8'h77, 1);
    vecs[20] = mk(0, 8'h00, 0, 0, 1, 1, 8'hA1, 2);
    vecs[21] = mk(0, 8'h00, 0, 0, 1, 1, 8'hA1, 2);
    vecs[22] = mk(0, 8'h00, 1, 0, 1, 1, 8'hA1, 2);
    vecs[23] = mk(0, 8'h00, 1, 0, 1, 1, 8'hB2, 1);
    vecs[24] = mk(0, 8'h00, 0, 0, 1, 0, 8'hB2, 0);
    // Flush with valid_i and ready_i both high
    vecs[25] = mk(1, 8'hC3, 0, 0, 1, 0, 8'hB2, 0);
    vecs[26] = mk(1, 8'hD4, 0, 0, 1, 0, 8'hB2, 1);
    vecs[27] = mk(1, 8'hE5, 1, 1, 0, 0, 8'hB2, 2);
    vecs[28] = mk(0, 8'h00, 1, 0, 1, 0, 8'hB2, 0);

    // ---------------- reset state ----------------
    @(negedge clk);
    #1;
    check("rst_valid_o", 0, 32'(a_valid_o), 32'd0);
    check("rst_count_o", 0, 32'(a_count), 32'd0);
    check("rst_data_o", 0, 32'(a_dout), 32'hA5);
    check("rst_ready_o", 0, 32'(a_ready_o), 32'd1);
    a_flush = 1'b1;
    #1;
    check("rst_flush_ready_o", 0, 32'(a_ready_o), 32'd0);
    a_flush = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // ---------------- vector table ----------------
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      a_valid = vecs[i].valid;
      a_din   = vecs[i].data;
      a_ready = vecs[i].ready;
      a_flush = vecs[i].flush;
      #1;
      check("ready_o", i, 32'(a_ready_o), 32'(vecs[i].exp_rdy));
      check("valid_o", i, 32'(a_valid_o), 32'(vecs[i].exp_vld));
      check("data_o",  i, 32'(a_dout),    32'(vecs[i].exp_data));
      check("count_o", i, 32'(a_count),   32'(vecs[i].exp_cnt));
    end

    // ---------------- async reset mid-stream ----------------
    @(negedge clk);
    a_valid = 1'b1; a_din = 8'hF1; a_ready = 1'b0; a_flush = 1'b0;
    @(negedge clk);
    a_din = 8'hF2;
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    check("arst_pre_count", 0, 32'(a_count), 32'd2);
    check("arst_pre_data", 0, 32'(a_dout), 32'hB2);
    #1;
    reset = 1'b1;
    #1;
    check("arst_valid_o", 0, 32'(a_valid_o), 32'd0);
    check("arst_count_o", 0, 32'(a_count), 32'd0);
    check("arst_data_o", 0, 32'(a_dout), 32'hA5);
    check("arst_ready_o", 0, 32'(a_ready_o), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    a_valid = 1'b1; a_din = 8'h99; a_ready = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    check("resume_valid_o", 1, 32'(a_valid_o), 32'd0);
    check("resume_count_o", 1, 32'(a_count), 32'd1);
    @(negedge clk);
    #1;
    check("resume_valid_o", 2, 32'(a_valid_o), 32'd0);
    check("resume_count_o", 2, 32'(a_count), 32'd1);
    @(negedge clk);
    #1;
    check("resume_valid_o", 3, 32'(a_valid_o), 32'd1);
    check("resume_data_o", 3, 32'(a_dout), 32'h99);
    check("resume_count_o", 3, 32'(a_count), 32'd1);

    // ---------------- DepthP=1 scoreboard stress ----------------
    q.delete();
    n_out = 0;
    for (int c = 0; c < 341; c++) begin
      logic exp_rdy, exp_vld;
      @(negedge clk);
      if (c < 300) begin
        b_valid = 1'($urandom_range(0, 1));
        b_ready = 1'($urandom_range(0, 1));
      end else if (c == 300) begin
        b_valid = 1'b0;           // drain before the throughput run
        b_ready = 1'b1;
      end else begin
        b_valid = 1'b1;
        b_ready = 1'b1;
      end
      b_din = 8'($urandom_range(0, 255));
      #1;
      exp_vld = (q.size() != 0);
      exp_rdy = (q.size() == 0) || b_ready;
      check("d1_valid_o", c, 32'(b_valid_o), 32'(exp_vld));
      check("d1_ready_o", c, 32'(b_ready_o), 32'(exp_rdy));
      check("d1_count_o", c, 32'(b_count), 32'(q.size()));
      if (exp_vld) check("d1_data_o", c, 32'(b_dout), 32'(q[0]));
      if (exp_vld && b_ready) begin
        void'(q.pop_front());
        if (c > 300) n_out++;
      end
      if (b_valid && exp_rdy) q.push_back(b_din);
    end
    // 40 cycles with both sides high: the first fills, the other 39 deliver.
    check("d1_throughput", 0, 32'(n_out), 32'd39);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pipe_reg
`default_nettype wire
